// File: rtl/instr_prefetch_buffer.sv
// Instruction fetch front end: owns the fetch PC, reads a combinational ROM and
// queues {pc, instr} pairs for decode; execute-stage redirects flush and restart fetch.
module instr_prefetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic [31:0]                  rom_addr,
   input  logic [31:0]                  rom_data,
   input  logic                         redirect_valid,
   input  logic [31:0]                  redirect_pc,
   output logic                         inst_valid,
   input  logic                         inst_ready,
   output logic [31:0]                  inst_data,
   output logic [31:0]                  inst_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   entry_pc_q    [DEPTH];
   logic [31:0]   entry_instr_q [DEPTH];

   logic empty_s, full_s, pop_s, push_s;
   logic unused_redirect_lsb_s;

   assign unused_redirect_lsb_s = ^redirect_pc[1:0];

   // Handshake qualifiers; a redirect suppresses both queue operations.
   always_comb begin
      empty_s = (count_q == '0);
      full_s  = (count_q == FULL_CNT);
      pop_s   = ~empty_s & inst_ready & ~redirect_valid;
      push_s  = ~redirect_valid & (~full_s | pop_s);
   end

   // Next-state for fetch PC, pointers and occupancy.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (push_s) begin
            wr_ptr_d   = wr_ptr_q + PW'(1);
            fetch_pc_d = fetch_pc_q + 32'd4;
         end else begin
            wr_ptr_d   = wr_ptr_q;
            fetch_pc_d = fetch_pc_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
      end
   end

   // Queue storage, cleared on reset so an empty queue presents zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_pc_q[i]    <= 32'd0;
            entry_instr_q[i] <= 32'd0;
         end
      end else if (push_s) begin
         entry_pc_q[wr_ptr_q]    <= fetch_pc_q;
         entry_instr_q[wr_ptr_q] <= rom_data;
      end
   end

   assign rom_addr   = fetch_pc_q;
   assign inst_valid = ~empty_s & ~redirect_valid;
   assign inst_data  = entry_instr_q[rd_ptr_q];
   assign inst_pc    = entry_pc_q[rd_ptr_q];
   assign count      = count_q;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Self-checking bench for instr_prefetch_buffer: directed scenarios plus random
// ready/redirect traffic compared against a queue-based reference model.
module tb_instr_prefetch_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, redirect_valid, inst_ready, inst_valid;
   logic [31:0] rom_addr, rom_data, redirect_pc, inst_data, inst_pc;
   logic [2:0]  count;

   logic        rst_n_w, ready_w, valid_w;
   logic [31:0] rom_addr_w, rom_data_w, data_w, pc_w;
   logic [2:0]  count_w;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] mq[$];
   logic [31:0] m_fpc;

   function automatic logic [31:0] rom_fn(input logic [31:0] a);
      return (a >> 2) + 32'd1;
   endfunction

   assign rom_data   = rom_fn(rom_addr);
   assign rom_data_w = rom_fn(rom_addr_w);

   instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_data(inst_data), .inst_pc(inst_pc), .count(count)
   );

   instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .rst_n(rst_n_w), .rom_addr(rom_addr_w), .rom_data(rom_data_w),
      .redirect_valid(1'b0), .redirect_pc(32'd0),
      .inst_valid(valid_w), .inst_ready(ready_w),
      .inst_data(data_w), .inst_pc(pc_w), .count(count_w)
   );

   // Advance the reference model by one edge from the current inputs, then wait past the edge.
   task automatic tick();
      bit v, full, pop;
      if (rst_n) begin
         v = (mq.size() != 0) && !redirect_valid;
         if (redirect_valid) begin
            mq.delete();
            m_fpc = redirect_pc & 32'hFFFF_FFFC;
         end else begin
            full = (mq.size() == DEPTH);
            pop  = v && inst_ready;
            if (pop) void'(mq.pop_front());
            if (!full || pop) begin
               mq.push_back({m_fpc, rom_fn(m_fpc)});
               m_fpc = m_fpc + 32'd4;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; inst_ready = 1'b0;
      mq.delete();
      m_fpc = 32'h0000_0000;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      #1;
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b exp=0", inst_valid); end
      n_checks++; if (inst_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", inst_data); end
      n_checks++; if (inst_pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", inst_pc); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
      n_checks++; if (rom_addr !== 32'd0) begin n_fail++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      inst_ready = 1'b0;
      repeat (4) tick();
      #1;
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count got=%0d exp=4", count); end
      n_checks++; if (rom_addr !== 32'h10) begin n_fail++; $display("FAIL fill_rom_addr got=%h exp=10", rom_addr); end
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid got=%0b exp=1", inst_valid); end
      n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL fill_head_pc got=%h exp=0", inst_pc); end
      n_checks++; if (inst_data !== 32'd1) begin n_fail++; $display("FAIL fill_head_data got=%h exp=1", inst_data); end
      tick();
      #1;
      n_checks++; if (rom_addr !== 32'h10) begin n_fail++; $display("FAIL full_hold_rom_addr got=%h exp=10", rom_addr); end
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_hold_count got=%0d exp=4", count); end
   endtask

   task automatic test_stream();
      apply_reset();
      rst_n = 1'b1;
      inst_ready = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         #1;
         n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid i=%0d got=%0b exp=1", i, inst_valid); end
         n_checks++; if (inst_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL stream_pc i=%0d got=%h exp=%h", i, inst_pc, 32'(i * 4)); end
         n_checks++; if (inst_data !== 32'(i + 1)) begin n_fail++; $display("FAIL stream_data i=%0d got=%h exp=%h", i, inst_data, 32'(i + 1)); end
         n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL stream_count i=%0d got=%0d exp=1", i, count); end
         tick();
      end
   endtask

   task automatic test_redirect();
      inst_ready = 1'b0;
      repeat (5) tick();
      redirect_valid = 1'b1; redirect_pc = 32'h1C;
      #1;
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_same_cycle_valid got=%0b exp=0", inst_valid); end
      tick();
      redirect_valid = 1'b0;
      #1;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL redir_count got=%0d exp=0", count); end
      n_checks++; if (rom_addr !== 32'h1C) begin n_fail++; $display("FAIL redir_rom_addr got=%h exp=1c", rom_addr); end
      n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_empty_valid got=%0b exp=0", inst_valid); end
      tick();
      #1;
      n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL redir_target_valid got=%0b exp=1", inst_valid); end
      n_checks++; if (inst_pc !== 32'h1C) begin n_fail++; $display("FAIL redir_target_pc got=%h exp=1c", inst_pc); end
      n_checks++; if (inst_data !== 32'd8) begin n_fail++; $display("FAIL redir_target_data got=%h exp=8", inst_data); end
   endtask

   task automatic test_misaligned();
      redirect_valid = 1'b1; redirect_pc = 32'h23;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_checks++; if (rom_addr !== 32'h20) begin n_fail++; $display("FAIL misalign_rom_addr got=%h exp=20", rom_addr); end
      inst_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         #1;
         n_checks++; if (inst_pc[1:0] !== 2'b00) begin n_fail++; $display("FAIL misalign_pc_lsb i=%0d got=%h", i, inst_pc); end
         n_checks++; if (inst_pc !== mq[0][63:32]) begin n_fail++; $display("FAIL misalign_head i=%0d got=%h exp=%h", i, inst_pc, mq[0][63:32]); end
      end
   endtask

   task automatic test_full_pop();
      logic [31:0] prev_head, prev_tail;
      inst_ready = 1'b0;
      repeat (5) tick();
      prev_head = mq[0][63:32];
      prev_tail = mq[mq.size()-1][63:32];
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      #1;
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fullpop_count got=%0d exp=4", count); end
      n_checks++; if (inst_pc !== prev_head + 32'd4) begin n_fail++; $display("FAIL fullpop_head got=%h exp=%h", inst_pc, prev_head + 32'd4); end
      n_checks++; if (rom_addr !== prev_tail + 32'd8) begin n_fail++; $display("FAIL fullpop_tail got=%h exp=%h", rom_addr, prev_tail + 32'd8); end
   endtask

   task automatic test_random();
      bit exp_v;
      for (int i = 0; i < 400; i++) begin
         inst_ready     = 1'($urandom_range(0, 1));
         redirect_valid = ($urandom_range(0, 19) == 0);
         redirect_pc    = 32'($urandom_range(0, 255));
         #1;
         exp_v = (mq.size() != 0) && !redirect_valid;
         n_checks++; if (inst_valid !== exp_v) begin n_fail++; $display("FAIL rand_valid i=%0d got=%0b exp=%0b", i, inst_valid, exp_v); end
         n_checks++; if (int'(count) != mq.size()) begin n_fail++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, count, mq.size()); end
         n_checks++; if (rom_addr !== m_fpc) begin n_fail++; $display("FAIL rand_rom_addr i=%0d got=%h exp=%h", i, rom_addr, m_fpc); end
         if (exp_v) begin
            n_checks++; if ({inst_pc, inst_data} !== mq[0]) begin n_fail++; $display("FAIL rand_head i=%0d got=%h_%h exp=%h", i, inst_pc, inst_data, mq[0]); end
         end
         tick();
      end
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
   endtask

   task automatic test_wrap_reset();
      logic [31:0] exp_pc [4];
      exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC;
      exp_pc[2] = 32'h0000_0000; exp_pc[3] = 32'h0000_0004;
      rst_n_w = 1'b1;
      ready_w = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++; if (valid_w !== 1'b1) begin n_fail++; $display("FAIL wrap_valid k=%0d got=%0b exp=1", k, valid_w); end
         n_checks++; if (pc_w !== exp_pc[k]) begin n_fail++; $display("FAIL wrap_pc k=%0d got=%h exp=%h", k, pc_w, exp_pc[k]); end
         n_checks++; if (data_w !== rom_fn(exp_pc[k])) begin n_fail++; $display("FAIL wrap_data k=%0d got=%h exp=%h", k, data_w, rom_fn(exp_pc[k])); end
         n_checks++; if (count_w !== 3'd1) begin n_fail++; $display("FAIL wrap_count k=%0d got=%0d exp=1", k, count_w); end
      end
      tick();
      #2;
      rst_n_w = 1'b0;
      #1;
      n_checks++; if (valid_w !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got=%0b exp=0", valid_w); end
      n_checks++; if (count_w !== 3'd0) begin n_fail++; $display("FAIL async_rst_count got=%0d exp=0", count_w); end
      n_checks++; if (rom_addr_w !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL async_rst_rom_addr got=%h exp=fffffff8", rom_addr_w); end
   endtask

   initial begin
      rst_n_w = 1'b0;
      ready_w = 1'b0;
      test_reset();
      test_fill();
      test_stream();
      test_redirect();
      test_misaligned();
      test_full_pop();
      test_random();
      test_wrap_reset();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
